fir_dsp_ctrl: RTL and testbench

Sequencer that runs an N-tap floating-point FIR on the single `dsp` DSPFP32 multiply-accumulate slice. It accepts one sample at a time over a valid/ready handshake and holds the delay line and a writable coefficient bank. For each sample it streams the tap operands and the accumulate-select bit into `dsp`, waits out the slice pipeline, and presents the filtered result with sticky FP exception flags on a valid/ready output.

---
 rtl/fir_dsp_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fir_dsp_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_dsp_ctrl.sv
// fir_dsp_ctrl: sequences an N-tap binary32 FIR through one external
// multiply-accumulate slice, one sample at a time.
module fir_dsp_ctrl #(
   parameter int unsigned FILTER_ORDER = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned COEFF_WIDTH  = 32,
   parameter int unsigned OUTPUT_WIDTH = 32,
   parameter int unsigned DSP_LATENCY  = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            s_valid_i,
   output logic                            s_ready_o,
   input  logic [DATA_WIDTH-1:0]           s_data_i,
   input  logic                            coef_we_i,
   input  logic [$clog2(FILTER_ORDER)-1:0] coef_addr_i,
   input  logic [COEFF_WIDTH-1:0]          coef_data_i,
   output logic                            m_valid_o,
   input  logic                            m_ready_i,
   output logic [OUTPUT_WIDTH-1:0]         m_data_o,
   output logic [2:0]                      m_flags_o,
   output logic [DATA_WIDTH-1:0]           dsp_x_o,
   output logic [COEFF_WIDTH-1:0]          dsp_h_o,
   output logic                            dsp_fpopmode_bit_o,
   input  logic [OUTPUT_WIDTH-1:0]         dsp_y_i,
   input  logic                            dsp_invalid_i,
   input  logic                            dsp_overflow_i,
   input  logic                            dsp_underflow_i
);

   localparam int unsigned TAP_W = $clog2(FILTER_ORDER);
   localparam int unsigned DRN_W = $clog2(DSP_LATENCY + 1);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(FILTER_ORDER - 1);
   localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(DSP_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_OUT   = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [DATA_WIDTH-1:0]   dline_q [FILTER_ORDER];
   logic [DATA_WIDTH-1:0]   dline_d [FILTER_ORDER];
   logic [COEFF_WIDTH-1:0]  coef_q  [FILTER_ORDER];
   logic [COEFF_WIDTH-1:0]  coef_d  [FILTER_ORDER];

   logic [TAP_W-1:0]        tap_q, tap_d;
   logic [DRN_W-1:0]        drn_q, drn_d;
   logic [2:0]              flags_q, flags_d;
   logic [OUTPUT_WIDTH-1:0] m_data_q, m_data_d;
   logic                    m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]   dsp_x_q, dsp_x_d;
   logic [COEFF_WIDTH-1:0]  dsp_h_q, dsp_h_d;
   logic                    dsp_mode_q, dsp_mode_d;

   logic                    s_fire_c;
   logic [TAP_W-1:0]        next_tap_c;

   assign s_ready_o          = (state_q == S_IDLE) & ~rst_i;
   assign s_fire_c           = s_valid_i & s_ready_o;
   assign next_tap_c         = tap_q + TAP_W'(1);

   assign m_valid_o          = m_valid_q;
   assign m_data_o           = m_data_q;
   assign m_flags_o          = flags_q;
   assign dsp_x_o            = dsp_x_q;
   assign dsp_h_o            = dsp_h_q;
   assign dsp_fpopmode_bit_o = dsp_mode_q;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (s_fire_c)            state_d = S_ISSUE;
         S_ISSUE: if (tap_q == LAST_TAP)   state_d = S_DRAIN;
         S_DRAIN: if (drn_q == LAST_DRN)   state_d = S_OUT;
         S_OUT:   if (m_ready_i)           state_d = S_IDLE;
         default:                          state_d = S_IDLE;
      endcase
   end

   // Datapath next values: tap issue, flag accumulation, result capture
   always_comb begin
      dline_d    = dline_q;
      coef_d     = coef_q;
      tap_d      = tap_q;
      drn_d      = drn_q;
      flags_d    = flags_q;
      m_data_d   = m_data_q;
      m_valid_d  = m_valid_q;
      dsp_x_d    = '0;
      dsp_h_d    = '0;
      dsp_mode_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (coef_we_i && (32'(coef_addr_i) < FILTER_ORDER)) begin
               coef_d[coef_addr_i] = coef_data_i;
            end
            if (s_fire_c) begin
               dline_d[0] = s_data_i;
               for (int k = 1; k < int'(FILTER_ORDER); k++) begin
                  dline_d[k] = dline_q[k-1];
               end
               tap_d      = '0;
               drn_d      = '0;
               flags_d    = '0;
               // Tap 0 issues from the incoming sample and always loads
               dsp_x_d    = s_data_i;
               dsp_h_d    = coef_q[0];
               dsp_mode_d = 1'b0;
            end
         end
         S_ISSUE: begin
            if (tap_q != LAST_TAP) begin
               tap_d      = next_tap_c;
               dsp_x_d    = dline_q[next_tap_c];
               dsp_h_d    = coef_q[next_tap_c];
               dsp_mode_d = 1'b1;
            end else begin
               drn_d = '0;
            end
         end
         S_DRAIN: begin
            flags_d = flags_q | {dsp_invalid_i, dsp_overflow_i, dsp_underflow_i};
            drn_d   = drn_q + DRN_W'(1);
            if (drn_q == LAST_DRN) begin
               m_data_d  = dsp_y_i;
               m_valid_d = 1'b1;
               drn_d     = '0;
            end
         end
         S_OUT: begin
            if (m_ready_i) begin
               m_valid_d = 1'b0;
            end
         end
         default: begin
            m_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < int'(FILTER_ORDER); k++) begin
            dline_q[k] <= '0;
            coef_q[k]  <= '0;
         end
         tap_q      <= '0;
         drn_q      <= '0;
         flags_q    <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         dsp_x_q    <= '0;
         dsp_h_q    <= '0;
         dsp_mode_q <= 1'b0;
      end else begin
         dline_q    <= dline_d;
         coef_q     <= coef_d;
         tap_q      <= tap_d;
         drn_q      <= drn_d;
         flags_q    <= flags_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         dsp_x_q    <= dsp_x_d;
         dsp_h_q    <= dsp_h_d;
         dsp_mode_q <= dsp_mode_d;
      end
   end

endmodule

// File: tb/tb_fir_dsp_ctrl.sv
// Bench for fir_dsp_ctrl with a behavioural 4-stage binary32 MAC slice.
module tb_fir_dsp_ctrl;

   localparam int unsigned N   = 4;
   localparam int unsigned LAT = 4;

   localparam logic [31:0] F1  = 32'h3F800000;
   localparam logic [31:0] F2  = 32'h40000000;
   localparam logic [31:0] F3  = 32'h40400000;
   localparam logic [31:0] F4  = 32'h40800000;
   localparam logic [31:0] F5  = 32'h40A00000;
   localparam logic [31:0] F8  = 32'h41000000;
   localparam logic [31:0] F9  = 32'h41100000;
   localparam logic [31:0] FMX = 32'h7F7FFFFF;
   localparam logic [31:0] FIN = 32'h7F800000;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        s_valid_i = 1'b0;
   logic        s_ready_o;
   logic [31:0] s_data_i = '0;
   logic        coef_we_i = 1'b0;
   logic [1:0]  coef_addr_i = '0;
   logic [31:0] coef_data_i = '0;
   logic        m_valid_o;
   logic        m_ready_i = 1'b0;
   logic [31:0] m_data_o;
   logic [2:0]  m_flags_o;
   logic [31:0] dsp_x_o;
   logic [31:0] dsp_h_o;
   logic        dsp_fpopmode_bit_o;
   logic [31:0] dsp_y_i;
   logic        dsp_invalid_i, dsp_overflow_i, dsp_underflow_i;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fir_dsp_ctrl dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .s_valid_i          (s_valid_i),
      .s_ready_o          (s_ready_o),
      .s_data_i           (s_data_i),
      .coef_we_i          (coef_we_i),
      .coef_addr_i        (coef_addr_i),
      .coef_data_i        (coef_data_i),
      .m_valid_o          (m_valid_o),
      .m_ready_i          (m_ready_i),
      .m_data_o           (m_data_o),
      .m_flags_o          (m_flags_o),
      .dsp_x_o            (dsp_x_o),
      .dsp_h_o            (dsp_h_o),
      .dsp_fpopmode_bit_o (dsp_fpopmode_bit_o),
      .dsp_y_i            (dsp_y_i),
      .dsp_invalid_i      (dsp_invalid_i),
      .dsp_overflow_i     (dsp_overflow_i),
      .dsp_underflow_i    (dsp_underflow_i)
   );

   // binary32 -> real (subnormals flushed to zero)
   function automatic real f2r(input logic [31:0] b);
      logic [63:0] d;
      logic [7:0]  e;
      e = b[30:23];
      if (e == 8'd0)        d = {b[31], 63'd0};
      else if (e == 8'hFF)  d = {b[31], 11'h7FF, b[22:0], 29'd0};
      else                  d = {b[31], 11'(e) + 11'd896, b[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // real -> {invalid, overflow, underflow, binary32} (truncating)
   function automatic logic [34:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      e = d[62:52];
      if (e == 11'h7FF) begin
         if (d[51:0] != 52'd0) return {3'b100, 32'h7FC00000};
         return {3'b000, d[63], 8'hFF, 23'd0};
      end
      if (e == 11'd0)     return {3'b000, d[63], 31'd0};
      if (e >= 11'd1151)  return {3'b010, d[63], 8'hFF, 23'd0};
      if (e <= 11'd896)   return {3'b001, d[63], 31'd0};
      return {3'b000, d[63], 8'(e - 11'd896), d[51:29]};
   endfunction

   function automatic logic [34:0] mac(input logic [31:0] x, input logic [31:0] h,
                                       input logic mode, input logic [31:0] acc);
      real p;
      p = f2r(x) * f2r(h);
      if (mode) p = f2r(acc) + p;
      return r2f(p);
   endfunction

   // MAC slice model: result of operands in cycle c appears in cycle c+LAT
   logic [31:0] acc_m = '0;
   logic [34:0] pipe_m [LAT];
   logic [34:0] res_m;
   initial for (int i = 0; i < int'(LAT); i++) pipe_m[i] = '0;
   assign res_m = mac(dsp_x_o, dsp_h_o, dsp_fpopmode_bit_o, acc_m);
   always @(posedge clk) begin
      acc_m     <= res_m[31:0];
      pipe_m[0] <= res_m;
      for (int i = 1; i < int'(LAT); i++) pipe_m[i] <= pipe_m[i-1];
   end
   assign dsp_y_i         = pipe_m[LAT-1][31:0];
   assign dsp_invalid_i   = pipe_m[LAT-1][34];
   assign dsp_overflow_i  = pipe_m[LAT-1][33];
   assign dsp_underflow_i = pipe_m[LAT-1][32];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic write_coef(input logic [1:0] addr, input logic [31:0] data);
      coef_we_i   = 1'b1;
      coef_addr_i = addr;
      coef_data_i = data;
      tick();
      coef_we_i   = 1'b0;
   endtask

   task automatic load_all(input logic [31:0] data);
      for (int k = 0; k < int'(N); k++) write_coef(2'(k), data);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   // Wait for a result with m_ready_i high, take it, complete the handshake
   task automatic wait_result(output logic [31:0] data, output logic [2:0] flags);
      bit seen;
      seen  = 1'b0;
      data  = '0;
      flags = '0;
      m_ready_i = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (m_valid_o) seen = 1'b1;
         else tick();
      end
      if (!seen) chk("result_timeout", 32'd0, 32'd1);
      else begin
         data  = m_data_o;
         flags = m_flags_o;
         tick();
      end
      m_ready_i = 1'b0;
   endtask

   task automatic run_sample(input logic [31:0] smp, output logic [31:0] data,
                             output logic [2:0] flags);
      s_valid_i = 1'b1;
      s_data_i  = smp;
      for (int i = 0; i < 20 && !s_ready_o; i++) tick();
      if (!s_ready_o) chk("accept_timeout", 32'd0, 32'd1);
      tick();
      s_valid_i = 1'b0;
      wait_result(data, flags);
   endtask

   typedef struct {
      logic [31:0] sample;
      logic [31:0] exp_data;
      logic [2:0]  exp_flags;
   } vec_t;

   vec_t        vecs [5];
   logic [31:0] rd;
   logic [2:0]  rf;
   bit          seen_v;

   initial begin
      vecs[0] = '{F1, 32'h3F800000, 3'b000};
      vecs[1] = '{F2, 32'h40400000, 3'b000};
      vecs[2] = '{F3, 32'h40C00000, 3'b000};
      vecs[3] = '{F4, 32'h41200000, 3'b000};
      vecs[4] = '{F5, 32'h41600000, 3'b000};

      // Reset state
      rst_i = 1'b1;
      tick(); tick();
      chk("rst_s_ready", 32'(s_ready_o), 32'd0);
      chk("rst_m_valid", 32'(m_valid_o), 32'd0);
      chk("rst_m_data", m_data_o, 32'd0);
      chk("rst_dsp_x", dsp_x_o, 32'd0);
      rst_i = 1'b0;
      tick();
      chk("post_rst_s_ready", 32'(s_ready_o), 32'd1);

      // Running sums with unit coefficients
      load_all(F1);
      for (int i = 0; i < 5; i++) begin
         run_sample(vecs[i].sample, rd, rf);
         chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
         chk($sformatf("vec%0d_flags", i), 32'(rf), 32'(vecs[i].exp_flags));
      end

      // Cycle-level timing of one sample with m_ready_i already high
      do_reset();
      load_all(F1);
      m_ready_i = 1'b1;
      s_valid_i = 1'b1;
      s_data_i  = F1;
      tick();
      s_valid_i = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c <= 4) chk($sformatf("mode_c%0d", c), 32'(dsp_fpopmode_bit_o), 32'(c != 1));
         if (c == 1) chk("x_tap0", dsp_x_o, F1);
         if (c == 6) chk("x_drain_zero", dsp_x_o, 32'd0);
         chk($sformatf("m_valid_c%0d", c), 32'(m_valid_o), 32'(c == 9));
         chk($sformatf("s_ready_c%0d", c), 32'(s_ready_o), 32'(c == 10));
         if (c == 9) chk("timing_data", m_data_o, F1);
         if (c < 10) tick();
      end
      m_ready_i = 1'b0;

      // Overflow sets sticky flag; next sample starts clean
      write_coef(2'd0, FMX);
      write_coef(2'd1, 32'd0);
      write_coef(2'd2, 32'd0);
      write_coef(2'd3, 32'd0);
      run_sample(F2, rd, rf);
      chk("ovf_data", rd, FIN);
      chk("ovf_flags", 32'(rf), 32'b010);
      load_all(F1);
      run_sample(F1, rd, rf);
      chk("after_ovf_data", rd, F4);
      chk("after_ovf_flags", 32'(rf), 32'b000);

      // Output backpressure; held input ignored
      s_valid_i = 1'b1;
      s_data_i  = F1;
      tick();
      s_valid_i = 1'b0;
      seen_v = 1'b0;
      for (int i = 0; i < 40 && !seen_v; i++) begin
         if (m_valid_o) seen_v = 1'b1;
         else tick();
      end
      chk("bp_seen", 32'(seen_v), 32'd1);
      s_valid_i = 1'b1;
      s_data_i  = F8;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_valid%0d", i), 32'(m_valid_o), 32'd1);
         chk($sformatf("bp_data%0d", i), m_data_o, F5);
         chk($sformatf("bp_flags%0d", i), 32'(m_flags_o), 32'd0);
         chk($sformatf("bp_s_ready%0d", i), 32'(s_ready_o), 32'd0);
         tick();
      end
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      s_valid_i = 1'b0;
      chk("bp_release_valid", 32'(m_valid_o), 32'd0);
      chk("bp_release_ready", 32'(s_ready_o), 32'd1);

      // Coefficient write during ISSUE is dropped
      s_valid_i = 1'b1;
      s_data_i  = F1;
      tick();
      s_valid_i = 1'b0;
      tick();
      coef_we_i   = 1'b1;
      coef_addr_i = 2'd0;
      coef_data_i = F2;
      tick();
      coef_we_i   = 1'b0;
      wait_result(rd, rf);
      chk("we_issue_data", rd, F5);
      // Same write in IDLE takes effect
      write_coef(2'd0, F2);
      run_sample(F3, rd, rf);
      chk("we_idle_data", rd, F9);

      // Reset during DRAIN discards the sample and clears history
      s_valid_i = 1'b1;
      s_data_i  = F4;
      tick();
      s_valid_i = 1'b0;
      for (int c = 1; c < 6; c++) tick();
      rst_i = 1'b1;
      #1;
      chk("rst_drain_s_ready", 32'(s_ready_o), 32'd0);
      tick();
      rst_i = 1'b0;
      chk("rst_drain_m_data", m_data_o, 32'd0);
      seen_v = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (m_valid_o) seen_v = 1'b1;
         tick();
      end
      chk("rst_drain_no_valid", 32'(seen_v), 32'd0);
      load_all(F1);
      run_sample(F1, rd, rf);
      chk("rst_drain_next_data", rd, F1);
      chk("rst_drain_next_flags", 32'(rf), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
